// File: rtl/goertzel_multi.sv
// goertzel_multi: multi-bin Goertzel power detector over one 2^LOG2_SAMPLES frame.
// Ports: dsp_clk, rst_n (sync, active-low); start, coef_wr/coef_idx/coef_val control;
//   sample_address/sample_data_in sample RAM port (1-cycle read latency); busy status;
//   mag_valid/mag_ready/mag_bin/mag_data result stream; frame_done end-of-frame pulse.
module goertzel_multi #(
  parameter int NUM_BINS     = 4,
  parameter int LOG2_SAMPLES = 9,
  parameter int D_W          = 16,
  parameter int S_W          = 8,
  parameter int FRAC         = 14
) (
  input  logic                    dsp_clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    coef_wr,
  input  logic [2:0]              coef_idx,
  input  logic [D_W-1:0]          coef_val,
  output logic [LOG2_SAMPLES-1:0] sample_address,
  input  logic [S_W-1:0]          sample_data_in,
  output logic                    busy,
  output logic                    mag_valid,
  input  logic                    mag_ready,
  output logic [2:0]              mag_bin,
  output logic [D_W-1:0]          mag_data,
  output logic                    frame_done
);

  localparam int PW = 2 * D_W;
  localparam int W2 = 2 * D_W + 2;
  localparam logic signed [W2-1:0] SAT_HI = {{(W2-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_LO = {{(W2-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, ITER, POST, OUT} state_t;

  state_t state_q, state_d;

  // Per-bin storage is sized for the 3-bit bin index so selects need no width games;
  // entries at or above NUM_BINS are never written.
  logic signed [D_W-1:0]    coef_q [8];
  logic signed [D_W-1:0]    s1_q   [8];
  logic signed [D_W-1:0]    s2_q   [8];
  logic [LOG2_SAMPLES-1:0]  addr_q;
  logic [2:0]               bin_q;
  logic [1:0]               post_cnt_q;
  logic signed [S_W-1:0]    x_q;
  logic signed [W2-1:0]     t_q;
  logic signed [W2-1:0]     e_q;
  logic [D_W-1:0]           mag_q;
  logic                     done_q;

  logic                     last_bin;
  logic                     last_smp;
  logic                     coef_ok;
  logic signed [S_W-1:0]    x_cur;
  logic signed [D_W-1:0]    c_cur;
  logic signed [D_W-1:0]    s1_cur;
  logic signed [D_W-1:0]    s2_cur;
  logic signed [PW-1:0]     cs1;
  logic signed [PW-1:0]     cs1_sh;
  logic signed [W2-1:0]     s0_full;
  logic signed [D_W-1:0]    s0_sat;
  logic signed [W2-1:0]     e_d;
  logic [D_W-1:0]           p_clamp;

  assign last_bin = (bin_q == 3'(NUM_BINS - 1));
  assign last_smp = (addr_q == {LOG2_SAMPLES{1'b1}});
  assign coef_ok  = ({1'b0, coef_idx} < 4'(NUM_BINS));

  // The RAM word is valid only in the first ITER cycle; later bins reuse the latched copy.
  assign x_cur  = (bin_q == 3'd0) ? $signed(sample_data_in) : x_q;
  assign c_cur  = coef_q[bin_q];
  assign s1_cur = s1_q[bin_q];
  assign s2_cur = s2_q[bin_q];

  assign cs1     = PW'(c_cur) * PW'(s1_cur);
  assign cs1_sh  = cs1 >>> FRAC;
  assign s0_full = W2'(x_cur) + W2'(cs1_sh) - W2'(s2_cur);

  always_comb begin
    s0_sat = s0_full[D_W-1:0];
    if (s0_full > SAT_HI) begin
      s0_sat = SAT_HI[D_W-1:0];
    end else if (s0_full < SAT_LO) begin
      s0_sat = SAT_LO[D_W-1:0];
    end
  end

  // Power: s1^2 + s2^2 - t*s2, with t = (C*s1)>>>FRAC registered in the first POST cycle.
  assign e_d = W2'(s1_cur) * W2'(s1_cur) + W2'(s2_cur) * W2'(s2_cur) - t_q * W2'(s2_cur);

  always_comb begin
    p_clamp = e_q[D_W-1:0];
    if (e_q[W2-1]) begin
      p_clamp = '0;
    end else if (|e_q[W2-2:D_W]) begin
      p_clamp = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = ITER;
      ITER:    if (last_bin) state_d = last_smp ? POST : FETCH;
      POST:    if (post_cnt_q == 2'd2) state_d = OUT;
      OUT:     if (mag_ready) state_d = last_bin ? IDLE : POST;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dsp_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      bin_q      <= '0;
      post_cnt_q <= '0;
      x_q        <= '0;
      t_q        <= '0;
      e_q        <= '0;
      mag_q      <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        coef_q[i] <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == OUT) && mag_ready && last_bin;
      case (state_q)
        IDLE: begin
          if (coef_wr && coef_ok) coef_q[coef_idx] <= coef_val;
          if (start) begin
            bin_q      <= '0;
            addr_q     <= '0;
            post_cnt_q <= '0;
            for (int i = 0; i < 8; i++) begin
              s1_q[i] <= '0;
              s2_q[i] <= '0;
            end
          end
        end
        FETCH: bin_q <= '0;
        ITER: begin
          if (bin_q == 3'd0) x_q <= $signed(sample_data_in);
          s2_q[bin_q] <= s1_cur;
          s1_q[bin_q] <= s0_sat;
          if (last_bin) begin
            bin_q  <= '0;
            addr_q <= addr_q + 1'b1;  // wraps to 0 after the last sample
          end else begin
            bin_q <= bin_q + 1'b1;
          end
        end
        POST: begin
          post_cnt_q <= (post_cnt_q == 2'd2) ? 2'd0 : post_cnt_q + 1'b1;
          case (post_cnt_q)
            2'd0:    t_q <= W2'(cs1_sh);
            2'd1:    e_q <= e_d;
            default: mag_q <= p_clamp;
          endcase
        end
        OUT: begin
          if (mag_ready) bin_q <= last_bin ? 3'd0 : bin_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sample_address = addr_q;
  assign busy           = (state_q != IDLE);
  assign mag_valid      = (state_q == OUT);
  assign mag_bin        = bin_q;
  assign mag_data       = mag_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_goertzel_multi.sv
// tb_goertzel_multi: randomized and directed frames for goertzel_multi (2 bins, 8 samples),
// checked against an arithmetic Goertzel model; results compared every cycle on the
// falling edge, inputs driven 1 time unit after the rising edge.
module tb_goertzel_multi;
  localparam int NB = 2;
  localparam int LG = 3;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int SW = 8;
  localparam int FR = 14;

  logic          dsp_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          coef_wr;
  logic [2:0]    coef_idx;
  logic [DW-1:0] coef_val;
  logic [LG-1:0] sample_address;
  logic [SW-1:0] sample_data_in;
  logic          busy;
  logic          mag_valid;
  logic          mag_ready;
  logic [2:0]    mag_bin;
  logic [DW-1:0] mag_data;
  logic          frame_done;

  goertzel_multi #(.NUM_BINS(NB), .LOG2_SAMPLES(LG), .D_W(DW), .S_W(SW), .FRAC(FR)) dut (
    .dsp_clk(dsp_clk), .rst_n(rst_n), .start(start), .coef_wr(coef_wr),
    .coef_idx(coef_idx), .coef_val(coef_val), .sample_address(sample_address),
    .sample_data_in(sample_data_in), .busy(busy), .mag_valid(mag_valid),
    .mag_ready(mag_ready), .mag_bin(mag_bin), .mag_data(mag_data), .frame_done(frame_done)
  );

  always #5 dsp_clk = ~dsp_clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int     mem    [N];
  int     coef_m [NB];
  longint ms1    [NB];
  longint ms2    [NB];
  longint mp_raw [NB];
  int     mp     [NB];
  longint peak;

  int  exp_dat_q [$];
  int  exp_bin_q [$];
  bit  exp_done   = 1'b0;
  int  done_count = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic compute_model();
    longint t, s0, p, mask;
    mask = (longint'(1) << 34) - 1;
    peak = 0;
    for (int b = 0; b < NB; b++) begin
      ms1[b] = 0;
      ms2[b] = 0;
    end
    for (int n = 0; n < N; n++) begin
      for (int b = 0; b < NB; b++) begin
        t  = (longint'(coef_m[b]) * ms1[b]) >>> FR;
        s0 = sat16(longint'(mem[n]) + t - ms2[b]);
        ms2[b] = ms1[b];
        ms1[b] = s0;
        if (s0 > peak) peak = s0;
        if (-s0 > peak) peak = -s0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      t = (longint'(coef_m[b]) * ms1[b]) >>> FR;
      p = ms1[b] * ms1[b] + ms2[b] * ms2[b] - t * ms2[b];
      p = p & mask;
      if (p >= (longint'(1) << 33)) p = p - (longint'(1) << 34);
      mp_raw[b] = p;
      if (p < 0) mp[b] = 0;
      else if (p > 65535) mp[b] = 65535;
      else mp[b] = int'(p);
    end
  endtask

  // Sample RAM with one cycle of read latency.
  initial begin
    logic [LG-1:0] addr_prev;
    addr_prev = '0;
    sample_data_in = '0;
    forever begin
      @(posedge dsp_clk);
      #1;
      sample_data_in = 8'(mem[addr_prev]);
      addr_prev = sample_address;
    end
  end

  // Compare process: result stream and frame_done against the expected queue.
  initial begin
    bit nd;
    forever begin
      @(negedge dsp_clk);
      nd = 1'b0;
      if (mag_valid) begin
        checks++;
        if (exp_dat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: mag_valid=1 bin=%0d data=%0d, required no pending result",
                   mag_bin, mag_data);
        end else if (int'(mag_bin) != exp_bin_q[0] || int'(mag_data) != exp_dat_q[0]) begin
          errors++;
          $display("FAIL result: got bin=%0d data=%0d expected bin=%0d data=%0d",
                   mag_bin, mag_data, exp_bin_q[0], exp_dat_q[0]);
        end
        if (mag_ready && exp_dat_q.size() != 0) begin
          void'(exp_dat_q.pop_front());
          void'(exp_bin_q.pop_front());
          if (exp_dat_q.size() == 0) nd = 1'b1;
        end
      end
      if (frame_done || exp_done) begin
        checks++;
        if (frame_done !== exp_done) begin
          errors++;
          $display("FAIL frame_done: got %0b expected %0b", frame_done, exp_done);
        end
      end
      if (frame_done) done_count++;
      exp_done = nd;
    end
  end

  task automatic write_coef(input int idx, input int val, input bit upd);
    logic signed [15:0] v;
    v = 16'(val);
    coef_wr  = 1'b1;
    coef_idx = 3'(idx);
    coef_val = v;
    @(posedge dsp_clk);
    #1;
    coef_wr = 1'b0;
    if (upd && idx < NB) coef_m[idx] = int'(v);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mag_valid"}, mag_valid, 0);
    check({tag, "_addr"}, sample_address, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_mag_bin"}, mag_bin, 0);
    check({tag, "_mag_data"}, mag_data, 0);
  endtask

  // mode 0: ready high; 1: random ready; 2: stall 10 cycles on first result with start pulses.
  task automatic run_frame(input int mode, input bit busy_wr);
    int k, d0;
    compute_model();
    for (int b = 0; b < NB; b++) begin
      exp_bin_q.push_back(b);
      exp_dat_q.push_back(mp[b]);
    end
    d0 = done_count;
    mag_ready = (mode != 2);
    start = 1'b1;
    @(posedge dsp_clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!mag_valid && k < 400) begin
      if (mode == 1) mag_ready = 1'($urandom);
      if (busy_wr) begin
        coef_wr  = (k == 5);
        coef_idx = 3'd1;
        coef_val = '0;
      end
      @(posedge dsp_clk);
      #1;
      k++;
    end
    coef_wr = 1'b0;
    check("first_valid_latency", k, N * (NB + 1) + 3);
    if (mode == 2) begin
      for (int i = 0; i < 10; i++) begin
        start = 1'(i);
        @(posedge dsp_clk);
        #1;
        check("stall_valid", mag_valid, 1);
        check("stall_busy", busy, 1);
      end
      start = 1'b0;
      mag_ready = 1'b1;
    end
    k = 0;
    while (done_count == d0 && k < 2000) begin
      if (mode == 1) mag_ready = 1'($urandom);
      @(posedge dsp_clk);
      #1;
      k++;
    end
    mag_ready = 1'b1;
    check("frame_done_count", done_count, d0 + 1);
    check("results_consumed", exp_dat_q.size(), 0);
    check("idle_after_frame", busy, 0);
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic load_pattern(input int amp);
    for (int n = 0; n < N; n++) begin
      case (n % 4)
        0:       mem[n] = amp;
        2:       mem[n] = -amp;
        default: mem[n] = 0;
      endcase
    end
  endtask

  task automatic load_random();
    for (int n = 0; n < N; n++) mem[n] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; coef_wr = 1'b0; coef_idx = '0; coef_val = '0; mag_ready = 1'b1;
    for (int n = 0; n < N; n++) mem[n] = 0;
    for (int b = 0; b < NB; b++) coef_m[b] = 0;
    repeat (3) @(posedge dsp_clk);
    #1;
    check_idle("por");
    rst_n = 1'b1;
    @(posedge dsp_clk);
    #1;

    // All-zero frame: two zero results, bin 0 then bin 1, then frame_done.
    write_coef(0, 0, 1);
    write_coef(1, 0, 1);
    run_frame(0, 1'b0);
    check("pin_zero_bin0", mp[0], 0);
    check("pin_zero_bin1", mp[1], 0);

    // C0 = 0, amplitude 16 alternating pattern.
    write_coef(1, int'($urandom_range(0, 65535)), 1);
    load_pattern(16);
    run_frame(0, 1'b0);
    check("pin_amp16_s1", ms1[0], 0);
    check("pin_amp16_s2", ms2[0], -64);
    check("pin_amp16_p", mp[0], 4096);

    // Same at amplitude 64: raw power 65536 clamps to 65535.
    load_pattern(64);
    run_frame(1, 1'b0);
    check("pin_amp64_s2", ms2[0], -256);
    check("pin_amp64_raw", mp_raw[0], 65536);
    check("pin_amp64_p", mp[0], 65535);

    // Back-pressure with start pulses during the stall.
    write_coef(0, int'($urandom_range(0, 65535)), 1);
    load_random();
    run_frame(2, 1'b0);

    // Large coefficient, full-scale samples; write attempts while busy or out of range.
    write_coef(1, 32767, 1);
    write_coef(5, 12345, 1);
    for (int n = 0; n < N; n++) mem[n] = 127;
    run_frame(0, 1'b1);
    check("pin_fullscale_p1", mp[1], 65535);
    check("pin_fullscale_peak_ok", (peak <= 32767) ? 1 : 0, 1);
    run_frame(1, 1'b0);

    // Reset in the middle of ITER aborts the frame.
    write_coef(0, int'($urandom_range(1, 65535)), 1);
    load_random();
    start = 1'b1;
    @(posedge dsp_clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge dsp_clk);
    #1;
    check("pre_reset_addr", sample_address, 1);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge dsp_clk);
    #1;
    check_idle("mid_reset");
    rst_n = 1'b1;
    for (int b = 0; b < NB; b++) coef_m[b] = 0;
    repeat (3) @(posedge dsp_clk);
    #1;
    load_random();
    run_frame(0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 5; f++) begin
      write_coef(0, int'($urandom_range(0, 65535)), 1);
      write_coef(1, int'($urandom_range(0, 65535)), 1);
      load_random();
      run_frame(1, 1'b0);
    end

    repeat (3) @(posedge dsp_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
